mem_stage_ctrl: RTL and testbench
=================================

# mem_stage_ctrl

Memory-stage access controller for the ARM pipeline: the responder at the far end of the MEM-stage register's `data_mem`/`freeze` inputs. It accepts load/store requests from the EXE→MEM pipeline register and performs each 32-bit access as two 16-bit off-chip SRAM cycles. It stalls the whole pipeline via `freeze` until the access completes, then presents the loaded word on `data_mem` for the MEM-stage register to capture.

## Interface
Parameters:
- `WAIT_CYCLES`, 2: cycles per 16-bit SRAM phase; legal range ≥2.
- `SRAM_AW`, 18: SRAM halfword address width.
- `MEM_BASE`, 1024: ARM byte address mapped to SRAM halfword 0.

Ports:
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_r_en`  in  1  load request, held by the frozen pipeline until completion.
- `mem_w_en`  in  1  store request, same hold rule.
- `alu_res`  in  32  byte address.
- `st_val`  in  32  store data.
- `data_mem`  out  32  registered load result.
- `freeze`  out  1  pipeline stall, combinational.
- `sram_addr`  out  SRAM_AW  halfword address.
- `sram_wdata`  out  16  write data.
- `sram_rdata`  in  16  read data, sampled at the end of each phase.
- `sram_we_n`  out  1  write strobe, active-low.
- `addr_err`  out  1  one-cycle out-of-range flag. Tied 0 unless MEM_ADDR_CHECK_EN.

## Operation
- Request: `req = mem_r_en | mem_w_en`. If both are set, the access is a write and `data_mem` is unchanged.
- Address mapping:
  - `off = alu_res - MEM_BASE`
  - `word = off[SRAM_AW:2]`
  - `sram_addr = {word[SRAM_AW-2:0], half}`, with `half` = 0 for LO and 1 for HI.
  - Bits [1:0] are ignored (word accesses only).
- FSM states IDLE, LO, HI, DONE:
  - IDLE: if `req`, go to LO and clear the counter.
  - LO: stay for WAIT_CYCLES cycles. On the last cycle, read accesses load `data_mem[15:0] <= sram_rdata`. Then go to HI.
  - HI: same rule, loading `data_mem[31:16]`. Then go to DONE.
  - DONE: always return to IDLE.
- `freeze = req & (state != DONE)`.
- Writes:
  - `sram_wdata` = `st_val[15:0]` in LO, `st_val[31:16]` in HI.
  - `sram_we_n` is low in every phase cycle except the last, which is the address/data hold cycle.
  - `sram_we_n` is high in IDLE, DONE, and during reads.
- Idle bus values: `sram_addr` and `sram_wdata` are 0 outside LO/HI.
- `data_mem` holds its value until the next read phase overwrites it.
- Reset values: `data_mem` 0, state IDLE, counter 0, `sram_we_n` 1, `sram_addr` 0, `sram_wdata` 0, `addr_err` 0.
- `freeze` follows `req` combinationally, even in reset.

## Timing
- A request seen in IDLE at cycle 0 occupies:
  - LO: cycles 1..W
  - HI: cycles W+1..2W
  - DONE: cycle 2W+1
- `freeze` is high for 2W+1 cycles and low in the DONE cycle. The MEM-stage register captures `data_mem` at the end of DONE.
- Back-to-back requests: the next instruction's request is seen in the cycle after DONE (IDLE) and starts immediately. No dead cycles beyond IDLE.
- Reset mid-access: `rst_n` low forces IDLE and `sram_we_n` high asynchronously. A partial write is left in SRAM and is not retried.
- A request that drops mid-access (only possible through reset or a flush bug) does not abort the current access. The FSM completes the access and discards the result.

## Configuration
- `MEM_ADDR_CHECK_EN` defined:
  - If `alu_res < MEM_BASE` or `off >= 2**(SRAM_AW+1)`, go IDLE→DONE directly.
  - No SRAM cycle; `data_mem` is cleared to 0.
  - `addr_err` pulses high in the DONE cycle; `freeze` is high for exactly 1 cycle.
- `MEM_ADDR_CHECK_EN` undefined: `addr_err` is 0 and the address wraps modulo SRAM size.

## Structure
- Package `arm_mem_pkg`:
  - state enum `mem_state_t` {IDLE, LO, HI, DONE}
  - `MEM_BASE_DEFAULT`
  - `SRAM_DW` = 16
- Sub-module `mem_wait_counter`:
  - clear/enable counter asserting `last` on count WAIT_CYCLES-1.
  - Instantiated once and shared by LO and HI.

## Test plan
- Reset with `rst_n`=0, no request → `freeze` 0, `data_mem` 0, `sram_we_n` 1, `sram_addr` 0.
- Store `alu_res`=1032, `st_val`=0xDEADBEEF, W=2:
  - cycle 1: `sram_addr` 4, `wdata` 0xBEEF, `we_n` 0
  - cycle 3: addr 5, 0xDEAD, `we_n` 0
  - `freeze` high in cycles 0–4, low in cycle 5
- Load 1032 from an SRAM model holding that data → `data_mem` = 0xDEADBEEF in DONE; `freeze` low for exactly one cycle.
- Load then store on consecutive instructions → the store's LO begins 2 cycles after the load's DONE (IDLE + LO); SRAM contents are correct.
- `rst_n` pulsed low during the HI phase of a store → `we_n` 1 immediately, state IDLE, `data_mem` 0; the next request runs normally.
- With `MEM_ADDR_CHECK_EN`, load `alu_res`=0x100 → `addr_err` 1 for one cycle, `freeze` 1 cycle, no `we_n`, `data_mem` 0. Without the macro, the load accesses the wrapped address.

Source files
------------

// File: rtl/mem_stage_ctrl_pkg.sv
// arm_mem_pkg: shared types for the MEM-stage SRAM controller.
// State encoding and SRAM bus width.
package arm_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LO,
      HI,
      DONE
   } mem_state_t;

   localparam int MEM_BASE_DEFAULT = 1024;
   localparam int SRAM_DW = 16;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: pipeline request/response and SRAM bus bundle.
// slave = controller side, master = pipeline + SRAM side.
interface mem_stage_ctrl_if
   import arm_mem_pkg::*;
#(
   parameter int SRAM_AW = 18
) ();

   logic               mem_r_en;
   logic               mem_w_en;
   logic [31:0]        alu_res;
   logic [31:0]        st_val;
   logic [31:0]        data_mem;
   logic               freeze;
   logic [SRAM_AW-1:0] sram_addr;
   logic [SRAM_DW-1:0] sram_wdata;
   logic [SRAM_DW-1:0] sram_rdata;
   logic               sram_we_n;
   logic               addr_err;

   modport master (
      output mem_r_en, mem_w_en, alu_res, st_val, sram_rdata,
      input  data_mem, freeze, sram_addr, sram_wdata, sram_we_n,
      input  addr_err
   );

   modport slave (
      input  mem_r_en, mem_w_en, alu_res, st_val, sram_rdata,
      output data_mem, freeze, sram_addr, sram_wdata, sram_we_n,
      output addr_err
   );

endinterface

// File: rtl/mem_stage_ctrl_wait_counter.sv
// mem_wait_counter: per-phase wait counter shared by LO and HI.
// last is high on count WAIT_CYCLES-1; wraps to 0 after it.
module mem_wait_counter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic last
);

   localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;

   logic [CW-1:0] cnt;

   assign last = (cnt == CW'(WAIT_CYCLES - 1));

   // count phase cycles, restart at each phase boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= last ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: 32-bit load/store as two 16-bit SRAM phases.
// Optional MEM_ADDR_CHECK_EN: reject out-of-range addresses.
module mem_stage_ctrl
   import arm_mem_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_AW     = 18,
   parameter int MEM_BASE    = MEM_BASE_DEFAULT
) (
   input logic          clk,
   input logic          rst_n,
   mem_stage_ctrl_if.slave bus
);

   localparam logic [31:0] BASE = 32'(MEM_BASE);

   mem_state_t         state;
   mem_state_t         nxt;
   logic               req;
   logic               op_wr;
   logic               err_q;
   logic               oor;
   logic               last;
   logic               clr;
   logic               en;
   logic [31:0]        off;
   logic [SRAM_AW-2:0] word;
   logic [31:0]        dm;
   logic [SRAM_AW-1:0] addr;
   logic [SRAM_DW-1:0] wdata;
   logic               we_n;
   logic               unused_ok;

   assign req  = bus.mem_r_en | bus.mem_w_en;
   assign off  = bus.alu_res - BASE;
   assign word = off[SRAM_AW:2];
   assign unused_ok = ^{off[1:0], off[31:SRAM_AW+1]};

`ifdef MEM_ADDR_CHECK_EN
   assign oor = (bus.alu_res < BASE) ||
                ({1'b0, off} >= (33'd1 << (SRAM_AW + 1)));
`else
   assign oor = 1'b0;
`endif

   mem_wait_counter #(
      .WAIT_CYCLES(WAIT_CYCLES)
   ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .en   (en),
      .last (last)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   // next state and SRAM bus drive
   always_comb begin
      nxt   = state;
      clr   = 1'b0;
      en    = 1'b0;
      addr  = '0;
      wdata = '0;
      we_n  = 1'b1;
      unique case (state)
         IDLE: begin
            clr = 1'b1;
            if (req) nxt = oor ? DONE : LO;
         end
         LO: begin
            en    = 1'b1;
            addr  = {word, 1'b0};
            wdata = bus.st_val[15:0];
            we_n  = ~(op_wr & ~last);
            if (last) nxt = HI;
         end
         HI: begin
            en    = 1'b1;
            addr  = {word, 1'b1};
            wdata = bus.st_val[31:16];
            we_n  = ~(op_wr & ~last);
            if (last) nxt = DONE;
         end
         DONE: begin
            clr = 1'b1;
            nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // latch op kind at start, capture read halves, clear on error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_wr <= 1'b0;
         err_q <= 1'b0;
         dm    <= '0;
      end else begin
         if (state == IDLE && req) begin
            op_wr <= bus.mem_w_en;
            err_q <= oor;
            if (oor) dm <= '0;
         end
         if (state == LO && last && !op_wr) dm[15:0]  <= bus.sram_rdata;
         if (state == HI && last && !op_wr) dm[31:16] <= bus.sram_rdata;
      end
   end

   assign bus.freeze     = req & (state != DONE);
   assign bus.data_mem   = dm;
   assign bus.sram_addr  = addr;
   assign bus.sram_wdata = wdata;
   assign bus.sram_we_n  = we_n;
   assign bus.addr_err   = err_q & (state == DONE);

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: scoreboard bench for mem_stage_ctrl with SRAM model.
// Build with +define+MEM_ADDR_CHECK_EN to exercise range checking.
module tb_mem_stage_ctrl;

   localparam int W  = 2;
   localparam int AW = 18;

   bit   clk;
   logic rst_n;

   mem_stage_ctrl_if #(.SRAM_AW(AW)) bus ();

   mem_stage_ctrl #(
      .WAIT_CYCLES(W),
      .SRAM_AW    (AW),
      .MEM_BASE   (1024)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   bit [15:0] sram [4096];
   assign bus.sram_rdata = sram[bus.sram_addr[11:0]];

   // SRAM model: write while strobe low at each clock
   always @(posedge clk) begin
      if (bus.sram_we_n == 1'b0) sram[bus.sram_addr[11:0]] <= bus.sram_wdata;
   end

   int checks;
   int failures;

   logic [31:0] ld_q [$];
   logic [17:0] wa_q [$];
   logic [15:0] wd_q [$];

   logic [17:0] tr_addr [64];
   logic [15:0] tr_wd   [64];
   logic        tr_we   [64];
   int          fz_n;
   logic [31:0] dm_done;
   logic        ae_done;

   task automatic access(input logic w, input logic r,
                         input logic [31:0] a, input logic [31:0] d);
      bus.mem_w_en = w;
      bus.mem_r_en = r;
      bus.alu_res  = a;
      bus.st_val   = d;
      fz_n = -1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         tr_addr[i] = bus.sram_addr;
         tr_wd[i]   = bus.sram_wdata;
         tr_we[i]   = bus.sram_we_n;
         if (!bus.freeze) begin
            fz_n    = i;
            dm_done = bus.data_mem;
            ae_done = bus.addr_err;
            break;
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      bus.mem_w_en = 1'b0;
      bus.mem_r_en = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.mem_r_en = 1'b0;
      bus.mem_w_en = 1'b0;
      bus.alu_res  = '0;
      bus.st_val   = '0;
      #2;
      checks++;
      if (bus.freeze !== 1'b0) begin
         failures++;
         $display("FAIL rst_freeze got=%b exp=0", bus.freeze);
      end
      checks++;
      if (bus.data_mem !== 32'h0) begin
         failures++;
         $display("FAIL rst_data_mem got=%h exp=0", bus.data_mem);
      end
      checks++;
      if (bus.sram_we_n !== 1'b1) begin
         failures++;
         $display("FAIL rst_we_n got=%b exp=1", bus.sram_we_n);
      end
      checks++;
      if (bus.sram_addr !== 18'h0 || bus.sram_wdata !== 16'h0) begin
         failures++;
         $display("FAIL rst_bus got=%h/%h exp=0/0", bus.sram_addr, bus.sram_wdata);
      end
      checks++;
      if (bus.addr_err !== 1'b0) begin
         failures++;
         $display("FAIL rst_addr_err got=%b exp=0", bus.addr_err);
      end
      bus.mem_r_en = 1'b1;
      #1;
      checks++;
      if (bus.freeze !== 1'b1) begin
         failures++;
         $display("FAIL rst_freeze_req got=%b exp=1", bus.freeze);
      end
      bus.mem_r_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_store();
      wa_q.push_back(18'd4);
      wd_q.push_back(16'hBEEF);
      wa_q.push_back(18'd5);
      wd_q.push_back(16'hDEAD);
      access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
      checks++;
      if (fz_n !== 5) begin
         failures++;
         $display("FAIL st_freeze_len got=%0d exp=5", fz_n);
      end
      checks++;
      if (tr_addr[1] !== 18'd4 || tr_wd[1] !== 16'hBEEF || tr_we[1] !== 1'b0) begin
         failures++;
         $display("FAIL st_lo got=%h/%h/%b exp=4/beef/0", tr_addr[1], tr_wd[1], tr_we[1]);
      end
      checks++;
      if (tr_we[2] !== 1'b1) begin
         failures++;
         $display("FAIL st_lo_hold got=%b exp=1", tr_we[2]);
      end
      checks++;
      if (tr_addr[3] !== 18'd5 || tr_wd[3] !== 16'hDEAD || tr_we[3] !== 1'b0) begin
         failures++;
         $display("FAIL st_hi got=%h/%h/%b exp=5/dead/0", tr_addr[3], tr_wd[3], tr_we[3]);
      end
      checks++;
      if (tr_we[4] !== 1'b1) begin
         failures++;
         $display("FAIL st_hi_hold got=%b exp=1", tr_we[4]);
      end
      checks++;
      if (tr_addr[5] !== 18'd0 || tr_wd[5] !== 16'd0 || tr_we[5] !== 1'b1) begin
         failures++;
         $display("FAIL st_done_bus got=%h/%h/%b exp=0/0/1", tr_addr[5], tr_wd[5], tr_we[5]);
      end
      while (wa_q.size() > 0) begin
         logic [17:0] a;
         logic [15:0] d;
         a = wa_q.pop_front();
         d = wd_q.pop_front();
         checks++;
         if (sram[a[11:0]] !== d) begin
            failures++;
            $display("FAIL st_sram[%0d] got=%h exp=%h", a, sram[a[11:0]], d);
         end
      end
   endtask

   task automatic test_load();
      logic [31:0] e;
      logic        wr_seen;
      ld_q.push_back(32'hDEADBEEF);
      access(1'b0, 1'b1, 32'd1032, 32'h0);
      e = ld_q.pop_front();
      checks++;
      if (dm_done !== e) begin
         failures++;
         $display("FAIL ld_data got=%h exp=%h", dm_done, e);
      end
      checks++;
      if (fz_n !== 5) begin
         failures++;
         $display("FAIL ld_freeze_len got=%0d exp=5", fz_n);
      end
      wr_seen = 1'b0;
      for (int i = 0; i < 6; i++) if (tr_we[i] !== 1'b1) wr_seen = 1'b1;
      checks++;
      if (wr_seen !== 1'b0) begin
         failures++;
         $display("FAIL ld_no_we got=%b exp=0", wr_seen);
      end
   endtask

   task automatic test_both_set();
      wa_q.push_back(18'd6);
      wd_q.push_back(16'hF00D);
      wa_q.push_back(18'd7);
      wd_q.push_back(16'h0BAD);
      access(1'b1, 1'b1, 32'd1036, 32'h0BADF00D);
      checks++;
      if (dm_done !== 32'hDEADBEEF) begin
         failures++;
         $display("FAIL both_data_kept got=%h exp=deadbeef", dm_done);
      end
      while (wa_q.size() > 0) begin
         logic [17:0] a;
         logic [15:0] d;
         a = wa_q.pop_front();
         d = wd_q.pop_front();
         checks++;
         if (sram[a[11:0]] !== d) begin
            failures++;
            $display("FAIL both_sram[%0d] got=%h exp=%h", a, sram[a[11:0]], d);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] e;
      ld_q.push_back({16'h0BAD, 16'hF00D});
      wa_q.push_back(18'd10);
      wd_q.push_back(16'h2468);
      wa_q.push_back(18'd11);
      wd_q.push_back(16'h1357);
      access(1'b0, 1'b1, 32'd1036, 32'h0);
      e = ld_q.pop_front();
      checks++;
      if (dm_done !== e) begin
         failures++;
         $display("FAIL b2b_ld_data got=%h exp=%h", dm_done, e);
      end
      access(1'b1, 1'b0, 32'd1044, 32'h13572468);
      checks++;
      if (tr_we[0] !== 1'b1 || tr_addr[0] !== 18'd0) begin
         failures++;
         $display("FAIL b2b_idle got=%b/%h exp=1/0", tr_we[0], tr_addr[0]);
      end
      checks++;
      if (tr_we[1] !== 1'b0 || tr_addr[1] !== 18'd10) begin
         failures++;
         $display("FAIL b2b_lo_start got=%b/%h exp=0/a", tr_we[1], tr_addr[1]);
      end
      checks++;
      if (fz_n !== 5) begin
         failures++;
         $display("FAIL b2b_freeze_len got=%0d exp=5", fz_n);
      end
      while (wa_q.size() > 0) begin
         logic [17:0] a;
         logic [15:0] d;
         a = wa_q.pop_front();
         d = wd_q.pop_front();
         checks++;
         if (sram[a[11:0]] !== d) begin
            failures++;
            $display("FAIL b2b_sram[%0d] got=%h exp=%h", a, sram[a[11:0]], d);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      bus.mem_w_en = 1'b1;
      bus.alu_res  = 32'd1040;
      bus.st_val   = 32'h12345678;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      checks++;
      if (bus.sram_we_n !== 1'b0 || bus.sram_addr !== 18'd9) begin
         failures++;
         $display("FAIL rm_in_hi got=%b/%h exp=0/9", bus.sram_we_n, bus.sram_addr);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.sram_we_n !== 1'b1 || bus.sram_addr !== 18'd0) begin
         failures++;
         $display("FAIL rm_async got=%b/%h exp=1/0", bus.sram_we_n, bus.sram_addr);
      end
      checks++;
      if (bus.data_mem !== 32'h0) begin
         failures++;
         $display("FAIL rm_data_mem got=%h exp=0", bus.data_mem);
      end
      checks++;
      if (bus.freeze !== 1'b1) begin
         failures++;
         $display("FAIL rm_freeze got=%b exp=1", bus.freeze);
      end
      bus.mem_w_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (sram[8] !== 16'h5678 || sram[9] !== 16'h0) begin
         failures++;
         $display("FAIL rm_partial got=%h/%h exp=5678/0", sram[8], sram[9]);
      end
      ld_q.push_back(32'hDEADBEEF);
      access(1'b0, 1'b1, 32'd1032, 32'h0);
      e = ld_q.pop_front();
      checks++;
      if (dm_done !== e || fz_n !== 5) begin
         failures++;
         $display("FAIL rm_next got=%h/%0d exp=%h/5", dm_done, fz_n, e);
      end
   endtask

   task automatic test_addr_range();
      logic [31:0] e;
`ifdef MEM_ADDR_CHECK_EN
      logic wr_seen;
      ld_q.push_back(32'h0);
      access(1'b0, 1'b1, 32'h100, 32'h0);
      e = ld_q.pop_front();
      checks++;
      if (fz_n !== 1) begin
         failures++;
         $display("FAIL ar_freeze_len got=%0d exp=1", fz_n);
      end
      checks++;
      if (ae_done !== 1'b1) begin
         failures++;
         $display("FAIL ar_addr_err got=%b exp=1", ae_done);
      end
      checks++;
      if (dm_done !== e) begin
         failures++;
         $display("FAIL ar_data got=%h exp=%h", dm_done, e);
      end
      wr_seen = 1'b0;
      for (int i = 0; i < 2; i++) if (tr_we[i] !== 1'b1) wr_seen = 1'b1;
      checks++;
      if (wr_seen !== 1'b0) begin
         failures++;
         $display("FAIL ar_no_we got=%b exp=0", wr_seen);
      end
      @(negedge clk);
      checks++;
      if (bus.addr_err !== 1'b0) begin
         failures++;
         $display("FAIL ar_pulse got=%b exp=0", bus.addr_err);
      end
      @(posedge clk);
      #1;
`else
      access(1'b1, 1'b0, 32'h100, 32'hCAFEF00D);
      checks++;
      if (tr_addr[1] !== 18'h3FE80 || tr_addr[3] !== 18'h3FE81) begin
         failures++;
         $display("FAIL ar_wrap_addr got=%h/%h exp=3fe80/3fe81", tr_addr[1], tr_addr[3]);
      end
      ld_q.push_back(32'hCAFEF00D);
      access(1'b0, 1'b1, 32'h100, 32'h0);
      e = ld_q.pop_front();
      checks++;
      if (dm_done !== e) begin
         failures++;
         $display("FAIL ar_wrap_data got=%h exp=%h", dm_done, e);
      end
      checks++;
      if (ae_done !== 1'b0 || fz_n !== 5) begin
         failures++;
         $display("FAIL ar_no_err got=%b/%0d exp=0/5", ae_done, fz_n);
      end
`endif
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_store();
      test_load();
      test_both_set();
      test_back_to_back();
      test_reset_mid();
      test_addr_range();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
